// File: rtl/release_arbiter.sv
// Burst-granular write arbiter between process memory (default priority) and special memory.
// Optional RELEASE_ARB_LEN_CHECK_EN adds a beat-count vs awlen check that pulses len_err.
module release_arbiter #(
    parameter int ID_WIDTH     = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 8,
    parameter int LEN_WIDTH    = 8,
    parameter int STARVE_LIMIT = 4,
    localparam int STRB_WIDTH  = (DATA_WIDTH >= 8) ? DATA_WIDTH / 8 : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  p_awvalid,
    input  logic [ID_WIDTH-1:0]   p_awid,
    input  logic [ADDR_WIDTH-1:0] p_awaddr,
    input  logic [LEN_WIDTH-1:0]  p_awlen,
    output logic                  p_awready,
    input  logic                  p_wvalid,
    input  logic [DATA_WIDTH-1:0] p_wdata,
    input  logic [STRB_WIDTH-1:0] p_wstrb,
    input  logic                  p_wlast,
    output logic                  p_wready,

    input  logic                  s_awvalid,
    input  logic [ID_WIDTH-1:0]   s_awid,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic [LEN_WIDTH-1:0]  s_awlen,
    output logic                  s_awready,
    input  logic                  s_wvalid,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [STRB_WIDTH-1:0] s_wstrb,
    input  logic                  s_wlast,
    output logic                  s_wready,

    input  logic                  spec_urgent,

    output logic                  m_awvalid,
    output logic [ID_WIDTH-1:0]   m_awid,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [LEN_WIDTH-1:0]  m_awlen,
    input  logic                  m_awready,
    output logic                  m_wvalid,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [STRB_WIDTH-1:0] m_wstrb,
    output logic                  m_wlast,
    input  logic                  m_wready,

    output logic [1:0]            grant,
    output logic                  len_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_q;
    logic [1:0] grant_q;
    logic [3:0] starve_q;
    logic [3:0] starve_d;

    logic in_addr;
    logic in_data;
    logic p_sel;
    logic s_sel;
    logic pick_spec;
    logic any_req;
    logic aw_fire;
    logic w_fire;

    assign in_addr = (state_q == ADDR);
    assign in_data = (state_q == DATA);
    assign p_sel   = grant_q[0];
    assign s_sel   = grant_q[1];
    assign any_req = p_awvalid | s_awvalid;

    // Special wins when alone, when its head is urgent, or once process has had its quota.
    assign pick_spec = s_awvalid & (~p_awvalid | spec_urgent | (starve_q >= LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (pick_spec) begin
            starve_d = 4'd0;
        end else if (s_awvalid && starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Downstream muxes: the owner's channel is visible only in its own phase.
    assign m_awvalid = in_addr & ((p_sel & p_awvalid) | (s_sel & s_awvalid));
    assign m_awid    = s_sel ? s_awid   : p_awid;
    assign m_awaddr  = s_sel ? s_awaddr : p_awaddr;
    assign m_awlen   = s_sel ? s_awlen  : p_awlen;

    assign m_wvalid  = in_data & ((p_sel & p_wvalid) | (s_sel & s_wvalid));
    assign m_wdata   = s_sel ? s_wdata : p_wdata;
    assign m_wstrb   = s_sel ? s_wstrb : p_wstrb;
    assign m_wlast   = s_sel ? s_wlast : p_wlast;

    assign p_awready = in_addr & p_sel & m_awready;
    assign s_awready = in_addr & s_sel & m_awready;
    assign p_wready  = in_data & p_sel & m_wready;
    assign s_wready  = in_data & s_sel & m_wready;

    assign aw_fire = m_awvalid & m_awready;
    assign w_fire  = m_wvalid & m_wready;

    assign grant = grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            starve_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q  <= ADDR;
                        grant_q  <= pick_spec ? 2'b10 : 2'b01;
                        starve_q <= starve_d;
                    end
                end
                ADDR: begin
                    if (aw_fire) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    // wlast alone ends the burst; awlen only feeds the optional check.
                    if (w_fire && m_wlast) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

`ifdef RELEASE_ARB_LEN_CHECK_EN
    logic [LEN_WIDTH-1:0] beat_cnt_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 len_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            len_q      <= '0;
            len_err_q  <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            if (aw_fire) begin
                len_q      <= m_awlen;
                beat_cnt_q <= '0;
            end
            if (w_fire) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
                if (m_wlast) begin
                    len_err_q <= (beat_cnt_q != len_q);
                end
            end
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

endmodule
